fifo_buffer: RTL

//  Parametrised synchronous FIFO replacing the edge-triggered single-channel buffer between pipeline

---
 rtl/fifo_buffer.sv | 115 +++++++++++
 1 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer
//   Parameterised synchronous FIFO for use between pipeline stages. Every entry
//   is usable because occupancy is tracked in a count register that is one bit
//   wider than the pointers. Overflow and underflow are held as sticky flags
//   until err_clr is pulsed.
//
//   Build option: FIFO_FWFT_EN
//     defined   - first-word-fall-through. dout shows the head entry without a
//                 clock edge, and dvalid = avail. re pops the word on dout.
//     undefined - registered read. dout and dvalid are updated on the edge
//                 after an accepted re (1-cycle latency). Reads can be issued
//                 on every cycle.
//
//   Parameters
//     BUF_ID     instance tag, kept for identification only
//     ADDR_L     pointer width, depth = 2**ADDR_L
//     DATA_L     data width
//     AFULL_TH   afull  = count >= AFULL_TH
//     AEMPTY_TH  aempty = count <= AEMPTY_TH
//
//   Ports
//     clk, rst      clock, synchronous active-high reset
//     we, din       write request and data
//     re            read request (accepted only when avail)
//     err_clr       clears the overflow/underflow sticky flags
//     dout, dvalid  read data and its valid flag
//     avail, full, afull, aempty, count   occupancy status
//     overflow, underflow                 sticky error flags
module fifo_buffer #(
    parameter int BUF_ID    = 0,
    parameter int ADDR_L    = 5,
    parameter int DATA_L    = 16,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_L-1:0] din,
    input  logic              re,
    input  logic              err_clr,
    output logic [DATA_L-1:0] dout,
    output logic              dvalid,
    output logic              avail,
    output logic              full,
    output logic              afull,
    output logic              aempty,
    output logic [ADDR_L:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_L;
    localparam logic [ADDR_L:0] DEPTH_C  = (ADDR_L+1)'(DEPTH);
    localparam logic [ADDR_L:0] AFULL_C  = (ADDR_L+1)'(AFULL_TH);
    localparam logic [ADDR_L:0] AEMPTY_C = (ADDR_L+1)'(AEMPTY_TH);

    logic [DATA_L-1:0] mem [DEPTH];
    logic [ADDR_L-1:0] rpt;
    logic [ADDR_L-1:0] wpt;
    logic              rd_ok;
    logic              wr_ok;

    assign avail  = (count != '0);
    assign full   = (count == DEPTH_C);
    assign afull  = (count >= AFULL_C);
    assign aempty = (count <= AEMPTY_C);

    // A write into a full FIFO succeeds when a read frees a slot on the same
    // edge. A read from an empty FIFO is rejected, so there is no bypass path.
    assign rd_ok = re & avail;
    assign wr_ok = we & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt       <= '0;
            wpt       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wpt <= wpt + 1'b1;
            if (rd_ok) rpt <= rpt + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // If a new error occurs in the same cycle as err_clr, the flag stays set.
            overflow  <= (overflow  & ~err_clr) | (we & ~wr_ok);
            underflow <= (underflow & ~err_clr) | (re & ~avail);
        end
    end

    // Memory contents are not cleared by reset. Only the pointers are reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wpt] <= din;
    end

`ifdef FIFO_FWFT_EN
    assign dout   = mem[rpt];
    assign dvalid = avail;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            dvalid <= rd_ok;
            if (rd_ok) dout <= mem[rpt];
        end
    end
`endif

endmodule
